// File: rtl/barrel_shifter_8_bit.sv
// Registered 8-bit barrel shifter/rotator with carry in/out and one-cycle latency.
// Optional macro ZERO_FLAG_EN adds a registered Zero_Out flag for an all-zero result.
module barrel_shifter_8_bit (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic       Enable_In,
    input  logic [2:0] Shifter_Mode_In,
    input  logic [2:0] Shift_Bits_Length_In,
    input  logic       Carry_In,
    input  logic [7:0] Data_In,
    output logic [7:0] Shifted_Data_Out,
    output logic       Carry_Out
`ifdef ZERO_FLAG_EN
    ,
    output logic       Zero_Out
`endif
);

    typedef enum logic [2:0] {
        LOGICAL_SHIFT_LEFT         = 3'h0,
        LOGICAL_SHIFT_RIGHT        = 3'h1,
        ARITHMETIC_SHIFT_LEFT      = 3'h2,
        ARITHMETIC_SHIFT_RIGHT     = 3'h3,
        ROTATE_LEFT                = 3'h4,
        ROTATE_RIGHT               = 3'h5,
        ROTATE_LEFT_THROUGH_CARRY  = 3'h6,
        ROTATE_RIGHT_THROUGH_CARRY = 3'h7
    } shift_mode_e;

    // One single-bit step on the 9-bit {carry, data} word. Shifts and plain
    // rotates overwrite the carry each step, so after the final step it holds
    // the last bit that left the byte; with n = 0 no step runs and the word
    // passes through with Carry_In untouched.
    function automatic logic [8:0] one_step(input shift_mode_e mode, input logic [8:0] v);
        logic       c;
        logic [7:0] d;
        logic [8:0] r;
        c = v[8];
        d = v[7:0];
        r = v;
        case (mode)
            LOGICAL_SHIFT_LEFT,
            ARITHMETIC_SHIFT_LEFT:      r = {d[7], d[6:0], 1'b0};
            LOGICAL_SHIFT_RIGHT:        r = {d[0], 1'b0, d[7:1]};
            ARITHMETIC_SHIFT_RIGHT:     r = {d[0], d[7], d[7:1]};
            ROTATE_LEFT:                r = {d[7], d[6:0], d[7]};
            ROTATE_RIGHT:               r = {d[0], d[0], d[7:1]};
            ROTATE_LEFT_THROUGH_CARRY:  r = {d[7], d[6:0], c};
            ROTATE_RIGHT_THROUGH_CARRY: r = {d[0], c, d[7:1]};
            default:                    r = v;
        endcase
        return r;
    endfunction

    function automatic logic [8:0] two_steps(input shift_mode_e mode, input logic [8:0] v);
        return one_step(mode, one_step(mode, v));
    endfunction

    function automatic logic [8:0] four_steps(input shift_mode_e mode, input logic [8:0] v);
        return two_steps(mode, two_steps(mode, v));
    endfunction

    shift_mode_e mode;
    logic [8:0]  stage_0;
    logic [8:0]  stage_1;
    logic [8:0]  stage_2;
    logic [8:0]  stage_4;

    assign mode = shift_mode_e'(Shifter_Mode_In);

    // Log shifter: stages of 1, 2 and 4 steps, each bypassed when its bit of n is 0.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        stage_0 = {Carry_In, Data_In};
        stage_1 = Shift_Bits_Length_In[0] ? one_step(mode, stage_0)   : stage_0;
        stage_2 = Shift_Bits_Length_In[1] ? two_steps(mode, stage_1)  : stage_1;
        stage_4 = Shift_Bits_Length_In[2] ? four_steps(mode, stage_2) : stage_2;
    end

    // NOTE: registered state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Shifted_Data_Out <= 8'h00;
            Carry_Out        <= 1'b0;
        end else if (Enable_In) begin
            Shifted_Data_Out <= stage_4[7:0];
            Carry_Out        <= stage_4[8];
        end
    end

`ifdef ZERO_FLAG_EN
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Zero_Out <= 1'b0;
        end else if (Enable_In) begin
            Zero_Out <= (stage_4[7:0] == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shifter_8_bit.sv
// Directed-vector bench for barrel_shifter_8_bit; expected values are hand-computed.
// Checks Zero_Out as well when built with ZERO_FLAG_EN.
module tb_barrel_shifter_8_bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [2:0] mode = 3'h0;
    logic [2:0] n    = 3'h0;
    logic       cin  = 1'b0;
    logic [7:0] d    = 8'h00;
    logic [7:0] q;
    logic       cout;
`ifdef ZERO_FLAG_EN
    logic       zout;
`endif

    int tests_run = 0;
    int fail_count = 0;

    barrel_shifter_8_bit dut (
        .Clock_In             (clk),
        .Reset_In             (rst),
        .Enable_In            (en),
        .Shifter_Mode_In      (mode),
        .Shift_Bits_Length_In (n),
        .Carry_In             (cin),
        .Data_In              (d),
        .Shifted_Data_Out     (q),
        .Carry_Out            (cout)
`ifdef ZERO_FLAG_EN
        ,
        .Zero_Out             (zout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, take one rising edge, settle 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [2:0] amt, input logic c, input logic [7:0] data);
        rst  = r;
        en   = e;
        mode = m;
        n    = amt;
        cin  = c;
        d    = data;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] exp_q, input logic exp_c);
        check({tag, " data"}, q, exp_q);
        check({tag, " carry"}, {7'd0, cout}, {7'd0, exp_c});
`ifdef ZERO_FLAG_EN
        check({tag, " zero"}, {7'd0, zout}, {7'd0, (exp_q == 8'h00)});
`endif
    endtask

    initial begin
        #2;
        // Reset beats enable.
        step(1'b1, 1'b1, 3'h0, 3'd3, 1'b1, 8'hFF);
        expect_out("reset", 8'h00, 1'b0);

        // Hold with enable low across two edges.
        step(1'b0, 1'b0, 3'h4, 3'd1, 1'b1, 8'h5A);
        expect_out("hold_after_reset_1", 8'h00, 1'b0);
        step(1'b0, 1'b0, 3'h7, 3'd5, 1'b1, 8'hC3);
        expect_out("hold_after_reset_2", 8'h00, 1'b0);

        // Main operations.
        step(1'b0, 1'b1, 3'h0, 3'd3, 1'b0, 8'hB5);
        expect_out("lsl_b5_3", 8'hA8, 1'b1);
        step(1'b0, 1'b1, 3'h1, 3'd0, 1'b1, 8'hB5);
        expect_out("lsr_b5_0_pass", 8'hB5, 1'b1);
        step(1'b0, 1'b1, 3'h0, 3'd0, 1'b0, 8'h3C);
        expect_out("lsl_3c_0_pass", 8'h3C, 1'b0);
        step(1'b0, 1'b1, 3'h3, 3'd2, 1'b0, 8'h96);
        expect_out("asr_96_2", 8'hE5, 1'b1);
        step(1'b0, 1'b1, 3'h1, 3'd2, 1'b0, 8'h96);
        expect_out("lsr_96_2", 8'h25, 1'b1);
        step(1'b0, 1'b1, 3'h5, 3'd1, 1'b0, 8'h81);
        expect_out("ror_81_1", 8'hC0, 1'b1);
        step(1'b0, 1'b1, 3'h4, 3'd7, 1'b0, 8'h81);
        expect_out("rol_81_7", 8'hC0, 1'b0);
        step(1'b0, 1'b1, 3'h6, 3'd1, 1'b1, 8'h80);
        expect_out("rcl_80_1_c1", 8'h01, 1'b1);
        step(1'b0, 1'b1, 3'h7, 3'd2, 1'b0, 8'h01);
        expect_out("rcr_01_2_c0", 8'h80, 1'b0);

        // Boundary amounts and carry-in ignored by plain shifts.
        step(1'b0, 1'b1, 3'h0, 3'd7, 1'b1, 8'h01);
        expect_out("lsl_01_7_c1", 8'h80, 1'b0);
        step(1'b0, 1'b1, 3'h1, 3'd7, 1'b1, 8'hC0);
        expect_out("lsr_c0_7", 8'h01, 1'b1);
        step(1'b0, 1'b1, 3'h3, 3'd7, 1'b1, 8'h80);
        expect_out("asr_80_7", 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'h3, 3'd7, 1'b0, 8'h7F);
        expect_out("asr_7f_7", 8'h00, 1'b1);
        step(1'b0, 1'b1, 3'h2, 3'd3, 1'b0, 8'hB5);
        expect_out("asl_b5_3", 8'hA8, 1'b1);
        step(1'b0, 1'b1, 3'h4, 3'd3, 1'b0, 8'hB5);
        expect_out("rol_b5_3", 8'hAD, 1'b1);
        step(1'b0, 1'b1, 3'h6, 3'd7, 1'b0, 8'hB5);
        expect_out("rcl_b5_7_c0", 8'hAD, 1'b0);
        step(1'b0, 1'b1, 3'h7, 3'd7, 1'b1, 8'h00);
        expect_out("rcr_00_7_c1", 8'h02, 1'b0);

        // Hold a nonzero result.
        step(1'b0, 1'b1, 3'h5, 3'd1, 1'b0, 8'h03);
        expect_out("ror_03_1", 8'h81, 1'b1);
        step(1'b0, 1'b0, 3'h0, 3'd4, 1'b0, 8'h0F);
        expect_out("hold_81", 8'h81, 1'b1);

        // Mid-stream reset with enable high, then resume.
        step(1'b1, 1'b1, 3'h0, 3'd1, 1'b1, 8'hFF);
        expect_out("reset_mid", 8'h00, 1'b0);

        // Back-to-back enabled cycles: each result lands exactly one edge later.
        step(1'b0, 1'b1, 3'h1, 3'd4, 1'b0, 8'hF0);
        expect_out("b2b_lsr_f0_4", 8'h0F, 1'b0);
        step(1'b0, 1'b1, 3'h0, 3'd4, 1'b0, 8'h0F);
        expect_out("b2b_lsl_0f_4", 8'hF0, 1'b0);
        step(1'b0, 1'b1, 3'h0, 3'd1, 1'b0, 8'h80);
        expect_out("b2b_lsl_80_1", 8'h00, 1'b1);
        step(1'b0, 1'b1, 3'h7, 3'd1, 1'b1, 8'h02);
        expect_out("b2b_rcr_02_1_c1", 8'h81, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
